// File: rtl/sl_controller.sv
// Second-layer controller: loads N filters, then per window loads 4 rows, clears, computes, accumulates, writes.
// Optional busy-cycle counter output enabled by defining SL_CTRL_PERF_CNT_EN.
module sl_controller #(
    parameter int N       = 2,
    parameter int NUM_WIN = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         window_valid,
    output logic         window_ready,
    input  logic         read_window_filter_counter_cout,
    output logic         load_filters_pc,
    output logic         write_filter_buff_counter_en,
    output logic [N-1:0] write_filter_buff_en,
    output logic         write_window_buff_en,
    output logic         write_window_buff_counter_en,
    output logic         read_window_filter_counter_en,
    output logic         shift_reg_en,
    output logic         reset_mac,
    output logic         partial_res_en,
    output logic         load_z_prime,
    output logic         write_mem_en,
    output logic         busy,
    output logic         done
`ifdef SL_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]  busy_cycles
`endif
);

    localparam int FCW = $clog2(4 * N) < 2 ? 2 : $clog2(4 * N);

    typedef enum logic [2:0] {
        IDLE, LOAD_FILTER, LOAD_WINDOW, CLR, CALC, ACC, WRITE, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [1:0]     row_q, row_d;
    logic [6:0]     win_q, win_d;

    logic           busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic           lpc_q, lpc_d, rd_q, rd_d, rmac_q, rmac_d;
    logic           pres_q, pres_d, wr_q, wr_d;
    logic [N-1:0]   fb_q, fb_d;
    logic           win_load;

    assign win_load = window_valid & ready_q;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        row_d   = row_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                fcnt_d = '0;
                row_d  = '0;
                win_d  = '0;
                if (start) state_d = LOAD_FILTER;
            end
            LOAD_FILTER: begin
                if (fcnt_q == FCW'(4 * N - 1)) begin
                    fcnt_d  = '0;
                    state_d = LOAD_WINDOW;
                end else begin
                    fcnt_d = fcnt_q + FCW'(1);
                end
            end
            LOAD_WINDOW: begin
                if (win_load) begin
                    if (row_q == 2'd3) begin
                        row_d   = '0;
                        state_d = CLR;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            CLR:  state_d = CALC;
            CALC: if (read_window_filter_counter_cout) state_d = ACC;
            ACC:  state_d = WRITE;
            WRITE: begin
                if (win_q < 7'(NUM_WIN - 1)) begin
                    win_d   = win_q + 7'd1;
                    state_d = LOAD_WINDOW;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        busy_d  = (state_d != IDLE);
        done_d  = 1'b0;
        ready_d = 1'b0;
        lpc_d   = 1'b0;
        fb_d    = '0;
        rd_d    = 1'b0;
        rmac_d  = 1'b0;
        pres_d  = 1'b0;
        wr_d    = 1'b0;
        case (state_d)
            LOAD_FILTER: begin
                lpc_d = 1'b1;
                fb_d  = N'(1) << (fcnt_d >> 2);
            end
            LOAD_WINDOW: ready_d = 1'b1;
            CLR:         rmac_d  = 1'b1;
            CALC:        rd_d    = 1'b1;
            ACC:         pres_d  = 1'b1;
            WRITE:       wr_d    = 1'b1;
            DONE:        done_d  = 1'b1;
            default:     ;
        endcase
    end

`ifdef SL_CTRL_PERF_CNT_EN
    logic [15:0] busy_cycles_q, busy_cycles_d;

    always_comb begin
        busy_cycles_d = busy_cycles_q;
        if (state_q == IDLE) begin
            if (start) busy_cycles_d = '0;
        end else if (busy_cycles_q != '1) begin
            busy_cycles_d = busy_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_cycles_q <= '0;
        else     busy_cycles_q <= busy_cycles_d;
    end

    assign busy_cycles = busy_cycles_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            row_q   <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            lpc_q   <= 1'b0;
            fb_q    <= '0;
            rd_q    <= 1'b0;
            rmac_q  <= 1'b0;
            pres_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            row_q   <= row_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            lpc_q   <= lpc_d;
            fb_q    <= fb_d;
            rd_q    <= rd_d;
            rmac_q  <= rmac_d;
            pres_q  <= pres_d;
            wr_q    <= wr_d;
        end
    end

    assign window_ready                  = ready_q;
    assign write_window_buff_en          = win_load;
    assign write_window_buff_counter_en  = win_load;
    assign load_filters_pc               = lpc_q;
    assign write_filter_buff_counter_en  = lpc_q;
    assign write_filter_buff_en          = fb_q;
    assign read_window_filter_counter_en = rd_q;
    assign shift_reg_en                  = rd_q;
    assign reset_mac                     = rmac_q;
    assign partial_res_en                = pres_q;
    assign load_z_prime                  = wr_q;
    assign write_mem_en                  = wr_q;
    assign busy                          = busy_q;
    assign done                          = done_q;

endmodule
